mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares the single-port synchronous word memory between two requesters: instruction fetch (IF) and load/store (LS).
- Sequences each access to the memory's strobes and address:
  - one access outstanding at a time;
  - fixed read latency of the memory, counted by a counter;
  - registered grant and response handshakes back to the requesters.
- Sits between the core's fetch/LSU stages and the memory instance.

Parameters:
- ADDR_W, 32, byte-address width of the requester ports and of mem_addr.
- DATA_W, 32, data width.
- MEM_LAT, 1, memory read latency in cycles, counted from the strobe cycle to valid mem_rdata. Legal range is 1..7.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- if_req  in  1  fetch request; held with if_addr until if_gnt.
- if_addr  in  ADDR_W  fetch byte address.
- if_gnt  out  1  one-cycle pulse; request accepted.
- if_rvalid  out  1  one-cycle pulse; if_rdata valid.
- if_rdata  out  DATA_W  fetch read data.
- ls_req  in  1  load/store request; held with ls_we, ls_addr and ls_wdata until ls_gnt.
- ls_we  in  1  1 = write, 0 = read.
- ls_addr  in  ADDR_W  load/store byte address.
- ls_wdata  in  DATA_W  store data.
- ls_gnt  out  1  one-cycle pulse; request accepted.
- ls_rvalid  out  1  one-cycle pulse, loads only.
- ls_rdata  out  DATA_W  load read data.
- mem_addr  out  ADDR_W  word index = {2'b00, addr[ADDR_W-1:2]}.
- mem_rd  out  1  memory read strobe.
- mem_wr  out  1  memory write strobe.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data.

Behaviour:
- Reset:
  - state goes to IDLE.
  - All outputs are registered and reset to 0: gnt, rvalid, rdata, mem_*.
  - Reset mid-access drops the in-flight response; no rvalid follows.
- States: IDLE, ACCESS, WAIT, RESP.
- IDLE or RESP, with any request present:
  - pick a winner; ls wins by default.
  - Register mem_addr, mem_rd = ~we, mem_wr = we, and mem_wdata.
  - Pulse the winner's gnt; go to ACCESS.
  - Grant and strobes are both visible in the cycle after the request was sampled.
- IDLE or RESP, no request: go to / stay in IDLE.
- ACCESS (strobes high for exactly 1 cycle):
  - Write: strobes go low; go to IDLE.
  - Read: load counter = MEM_LAT-1; go to WAIT.
- WAIT:
  - Strobes are low and mem_addr is held.
  - While counter != 0, decrement.
  - When counter == 0, capture mem_rdata into the owner's rdata, pulse the owner's rvalid next cycle, and go to RESP.
- Read latency: request sampled in cycle N gives rvalid in cycle N+2+MEM_LAT (N+3 for MEM_LAT=1).
- RESP arbitrates like IDLE, so reads can be back-to-back.
- Write turnaround: after a write, the next grant comes from IDLE.
- Requests raised while busy are ignored until the next IDLE/RESP sample. Requesters must hold them.
- rdata holds its last value; only the owner's rdata changes.
- Address low bits [1:0] are ignored; misaligned accesses are not flagged.
- Simultaneous if_req and ls_req: ls is granted and if is held off.

Optional Feature:
- Macro: MEM_ARB_RR_EN.
- Defined: round-robin on simultaneous requests.
  - A 1-bit last-winner register decides, reset to IF (so LS wins first after reset).
  - The winner alternates while both keep requesting.
- Undefined: fixed LS-over-IF priority.
  - IF can starve while LS requests continuously.

Decomposition:
- Shared package mem_arb_pkg holds:
  - state encoding constants: IDLE=2'd0, ACCESS=2'd1, WAIT=2'd2, RESP=2'd3;
  - requester IDs: REQ_IF=1'b0, REQ_LS=1'b1;
  - MEM_LAT range limits.
- One natural sub-module, arb_pick:
  - combinational 2-way picker (fixed priority or round-robin under the macro);
  - the last-winner register stays in the parent.

Test Plan:
- rst=1 during a read in WAIT, released 2 cycles later: no if_rvalid/ls_rvalid, mem_rd=0, state IDLE. Next request is served normally.
- Single IF read: if_addr=0x8, mem preloaded word[2]=0x00108213, request at cycle 0. Expect if_gnt at cycle 1, mem_rd=1 and mem_addr=2 at cycle 1, if_rvalid=1 with if_rdata=0x00108213 at cycle 3.
- LS write then read: ls_we=1, ls_addr=0x4, ls_wdata=0xDEADBEEF; then ls_we=0, ls_addr=0x4. Expect mem_wr pulse with mem_addr=1, then ls_rdata=0xDEADBEEF and no ls_rvalid for the write.
- Both request continuously, macro undefined: only ls_gnt for 5 grants, if_gnt=0. With MEM_ARB_RR_EN: grants alternate LS, IF, LS, IF.
- Back-to-back IF reads at addresses 0x0 and 0x4: second if_gnt in the RESP cycle of the first. rvalids arrive 3 cycles apart (MEM_LAT=1).
- MEM_LAT=3: read issued at cycle 0 gives rvalid at cycle 5, and strobes stay low in the WAIT cycles.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the IF/LS memory arbiter: FSM state encoding,
// requester IDs and the supported memory-latency range.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      WAIT   = 2'd2,
      RESP   = 2'd3
   } state_e;

   localparam logic REQ_IF = 1'b0;
   localparam logic REQ_LS = 1'b1;

   localparam int MEM_LAT_MIN = 1;
   localparam int MEM_LAT_MAX = 7;
   localparam int CNT_W       = 3;

endpackage

// File: rtl/mem_arbiter_pick.sv
// Combinational two-way picker between fetch and load/store requests.
// Fixed LS priority by default; MEM_ARB_RR_EN alternates on simultaneous requests.
module arb_pick
   import mem_arb_pkg::*;
(
   input  logic if_req_i,
   input  logic ls_req_i,
   input  logic last_i,
   output logic vld_o,
   output logic win_o
);

   always_comb begin
      vld_o = if_req_i | ls_req_i;
`ifdef MEM_ARB_RR_EN
      if (if_req_i && ls_req_i) begin
         win_o = ~last_i;
      end else begin
         win_o = ls_req_i ? REQ_LS : REQ_IF;
      end
`else
      win_o = ls_req_i ? REQ_LS : REQ_IF;
`endif
   end

`ifndef MEM_ARB_RR_EN
   logic unused_last;
   assign unused_last = last_i;
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter for fetch and load/store, one access in flight,
// fixed read latency counted in WAIT. Optional round-robin via MEM_ARB_RR_EN.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int MEM_LAT = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_gnt,
   output logic              if_rvalid,
   output logic [DATA_W-1:0] if_rdata,
   input  logic              ls_req,
   input  logic              ls_we,
   input  logic [ADDR_W-1:0] ls_addr,
   input  logic [DATA_W-1:0] ls_wdata,
   output logic              ls_gnt,
   output logic              ls_rvalid,
   output logic [DATA_W-1:0] ls_rdata,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_rd,
   output logic              mem_wr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   // Out-of-range latencies are clamped so the counter always fits.
   localparam int LAT_C = (MEM_LAT < MEM_LAT_MIN) ? MEM_LAT_MIN :
                          (MEM_LAT > MEM_LAT_MAX) ? MEM_LAT_MAX : MEM_LAT;

   state_e             state_q;
   logic               own_q;
   logic [CNT_W-1:0]   cnt_q;
   logic               if_gnt_q, ls_gnt_q, if_rvalid_q, ls_rvalid_q;
   logic [DATA_W-1:0]  if_rdata_q, ls_rdata_q, mem_wdata_q;
   logic [ADDR_W-1:0]  mem_addr_q;
   logic               mem_rd_q, mem_wr_q;
   logic               last_q;

   logic               pick_vld, pick_win;
   logic               we_d;
   logic [ADDR_W-1:0]  addr_d;
   logic [DATA_W-1:0]  wdata_d;
   logic [1:0]         unused_lsb;

   arb_pick u_pick (
      .if_req_i (if_req),
      .ls_req_i (ls_req),
      .last_i   (last_q),
      .vld_o    (pick_vld),
      .win_o    (pick_win)
   );

   assign we_d       = (pick_win == REQ_LS) ? ls_we : 1'b0;
   assign addr_d     = (pick_win == REQ_LS) ? ls_addr : if_addr;
   assign wdata_d    = (pick_win == REQ_LS) ? ls_wdata : '0;
   assign unused_lsb = addr_d[1:0];

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         own_q       <= REQ_IF;
         cnt_q       <= '0;
         if_gnt_q    <= 1'b0;
         ls_gnt_q    <= 1'b0;
         if_rvalid_q <= 1'b0;
         ls_rvalid_q <= 1'b0;
         if_rdata_q  <= '0;
         ls_rdata_q  <= '0;
         mem_addr_q  <= '0;
         mem_rd_q    <= 1'b0;
         mem_wr_q    <= 1'b0;
         mem_wdata_q <= '0;
         last_q      <= REQ_IF;
      end else begin
         if_gnt_q    <= 1'b0;
         ls_gnt_q    <= 1'b0;
         if_rvalid_q <= 1'b0;
         ls_rvalid_q <= 1'b0;
         mem_rd_q    <= 1'b0;
         mem_wr_q    <= 1'b0;
         case (state_q)
            IDLE, RESP: begin
               if (pick_vld) begin
                  own_q       <= pick_win;
                  if_gnt_q    <= (pick_win == REQ_IF);
                  ls_gnt_q    <= (pick_win == REQ_LS);
                  mem_addr_q  <= {2'b00, addr_d[ADDR_W-1:2]};
                  mem_rd_q    <= ~we_d;
                  mem_wr_q    <= we_d;
                  mem_wdata_q <= wdata_d;
`ifdef MEM_ARB_RR_EN
                  last_q      <= pick_win;
`endif
                  state_q     <= ACCESS;
               end else begin
                  state_q <= IDLE;
               end
            end
            ACCESS: begin
               // Writes complete in the strobe cycle; reads start the latency count.
               if (mem_wr_q) begin
                  state_q <= IDLE;
               end else begin
                  cnt_q   <= CNT_W'(LAT_C - 1);
                  state_q <= WAIT;
               end
            end
            WAIT: begin
               if (cnt_q != '0) begin
                  cnt_q <= cnt_q - 1'b1;
               end else begin
                  if (own_q == REQ_LS) begin
                     ls_rdata_q  <= mem_rdata;
                     ls_rvalid_q <= 1'b1;
                  end else begin
                     if_rdata_q  <= mem_rdata;
                     if_rvalid_q <= 1'b1;
                  end
                  state_q <= RESP;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign if_gnt    = if_gnt_q;
   assign ls_gnt    = ls_gnt_q;
   assign if_rvalid = if_rvalid_q;
   assign ls_rvalid = ls_rvalid_q;
   assign if_rdata  = if_rdata_q;
   assign ls_rdata  = ls_rdata_q;
   assign mem_addr  = mem_addr_q;
   assign mem_rd    = mem_rd_q;
   assign mem_wr    = mem_wr_q;
   assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed vector table, hand sequences for reset,
// contention, back-to-back and MEM_LAT=3, then a random run against a transaction model.
`timescale 1ns/1ps
module tb_mem_arbiter;

   localparam int LAT  = 1;
   localparam int LAT3 = 3;
`ifdef MEM_ARB_RR_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic        if_req, ls_req, ls_we;
   logic [31:0] if_addr, ls_addr, ls_wdata;
   logic        if_gnt, if_rvalid, ls_gnt, ls_rvalid, mem_rd, mem_wr;
   logic [31:0] if_rdata, ls_rdata, mem_addr, mem_wdata, mem_rdata;

   logic        if_req3;
   logic [31:0] if_addr3;
   logic        if_gnt3, if_rvalid3, ls_gnt3, ls_rvalid3, mem_rd3, mem_wr3;
   logic [31:0] if_rdata3, ls_rdata3, mem_addr3, mem_wdata3_unused, mem_rdata3;

   mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT)) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
      .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
      .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
      .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT3)) dut3 (
      .clk(clk), .rst(rst),
      .if_req(if_req3), .if_addr(if_addr3), .if_gnt(if_gnt3), .if_rvalid(if_rvalid3), .if_rdata(if_rdata3),
      .ls_req(1'b0), .ls_we(1'b0), .ls_addr(32'h0), .ls_wdata(32'h0),
      .ls_gnt(ls_gnt3), .ls_rvalid(ls_rvalid3), .ls_rdata(ls_rdata3),
      .mem_addr(mem_addr3), .mem_rd(mem_rd3), .mem_wr(mem_wr3), .mem_wdata(mem_wdata3_unused), .mem_rdata(mem_rdata3)
   );

   // Memory environment: preload pattern plus written words, read pipeline of LAT stages.
   function automatic logic [31:0] init_val(input int i);
      if (i == 2) return 32'h00108213;
      if (i == 5) return 32'hCAFEF00D;
      return 32'h5A5A0000 ^ (32'(i) * 32'h01010101);
   endfunction

   logic [31:0] mem [256];
   bit          wv  [256];
   logic [31:0] pipe1;
   logic [31:0] pipe3 [3];

   always @(posedge clk) begin
      if (mem_wr) begin
         mem[mem_addr[7:0]] <= mem_wdata;
         wv[mem_addr[7:0]]  <= 1'b1;
      end
      pipe1 <= mem_rd ? (wv[mem_addr[7:0]] ? mem[mem_addr[7:0]] : init_val(int'(mem_addr[7:0])))
                      : 32'hBADBAD01;
      pipe3[0] <= mem_rd3 ? init_val(int'(mem_addr3[7:0])) : 32'hBADBAD03;
      pipe3[1] <= pipe3[0];
      pipe3[2] <= pipe3[1];
   end
   assign mem_rdata  = pipe1;
   assign mem_rdata3 = pipe3[2];

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   function automatic logic [31:0] flags();
      return 32'({if_gnt, if_rvalid, ls_gnt, ls_rvalid, mem_rd, mem_wr});
   endfunction

   function automatic logic [31:0] flags3();
      return 32'({if_gnt3, if_rvalid3, ls_gnt3, ls_rvalid3, mem_rd3, mem_wr3});
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_in();
      if_req = 1'b0; if_addr = '0; ls_req = 1'b0; ls_we = 1'b0; ls_addr = '0; ls_wdata = '0;
      if_req3 = 1'b0; if_addr3 = '0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      idle_in();
      step();
      step();
      rst = 1'b0;
   endtask

   typedef struct {
      logic        ifr;
      logic [31:0] ifa;
      logic        lsr, lswe;
      logic [31:0] lsa, lsw;
      logic [5:0]  e_flags;
      logic [31:0] e_ifd, e_lsd, e_ma;
   } vec_t;

   function automatic vec_t mkv(input logic ifr, input logic [31:0] ifa, input logic lsr, input logic lswe,
                                input logic [31:0] lsa, input logic [31:0] lsw, input logic [5:0] ef,
                                input logic [31:0] ifd, input logic [31:0] lsd, input logic [31:0] ma);
      vec_t v;
      v.ifr = ifr; v.ifa = ifa; v.lsr = lsr; v.lswe = lswe; v.lsa = lsa; v.lsw = lsw;
      v.e_flags = ef; v.e_ifd = ifd; v.e_lsd = lsd; v.e_ma = ma;
      return v;
   endfunction

   vec_t        tv [10];
   logic [31:0] mref [256];
   bit          wins [5];

   initial begin
      int ng;
      int free_at, rv_cyc;
      bit last_ls, rv_ls, p_if, p_ls, l_we, win_ls, we;
      logic [31:0] rv_dat, if_a, l_a, l_w, a;
      bit e_gif, e_gls, e_rd, e_wr;
      logic [31:0] e_ma, e_wd;

      // flags order: {if_gnt, if_rvalid, ls_gnt, ls_rvalid, mem_rd, mem_wr}
      tv[0] = mkv(1, 32'h8, 0, 0, 0, 0,             6'b000000, 32'h0,        32'h0,        32'h0);
      tv[1] = mkv(0, 0,     0, 0, 0, 0,             6'b100010, 32'h0,        32'h0,        32'h2);
      tv[2] = mkv(0, 0,     0, 0, 0, 0,             6'b000000, 32'h0,        32'h0,        32'h2);
      tv[3] = mkv(0, 0,     1, 1, 32'h4, 32'hDEADBEEF, 6'b010000, 32'h00108213, 32'h0,     32'h2);
      tv[4] = mkv(0, 0,     1, 0, 32'h4, 0,         6'b001001, 32'h00108213, 32'h0,        32'h1);
      tv[5] = mkv(0, 0,     1, 0, 32'h4, 0,         6'b000000, 32'h00108213, 32'h0,        32'h1);
      tv[6] = mkv(0, 0,     0, 0, 0, 0,             6'b001010, 32'h00108213, 32'h0,        32'h1);
      tv[7] = mkv(0, 0,     0, 0, 0, 0,             6'b000000, 32'h00108213, 32'h0,        32'h1);
      tv[8] = mkv(0, 0,     0, 0, 0, 0,             6'b000100, 32'h00108213, 32'hDEADBEEF, 32'h1);
      tv[9] = mkv(0, 0,     0, 0, 0, 0,             6'b000000, 32'h00108213, 32'hDEADBEEF, 32'h1);

      do_reset();
      chk("reset_flags", flags(), 32'h0);
      chk("reset_if_rdata", if_rdata, 32'h0);
      chk("reset_ls_rdata", ls_rdata, 32'h0);
      chk("reset_mem_addr", mem_addr, 32'h0);
      chk("reset_mem_wdata", mem_wdata, 32'h0);

      for (int i = 0; i < 10; i++) begin
         chk($sformatf("vec%0d_flags", i), flags(), 32'(tv[i].e_flags));
         chk($sformatf("vec%0d_if_rdata", i), if_rdata, tv[i].e_ifd);
         chk($sformatf("vec%0d_ls_rdata", i), ls_rdata, tv[i].e_lsd);
         chk($sformatf("vec%0d_mem_addr", i), mem_addr, tv[i].e_ma);
         if (i == 4) chk("vec4_mem_wdata", mem_wdata, 32'hDEADBEEF);
         if_req = tv[i].ifr; if_addr = tv[i].ifa;
         ls_req = tv[i].lsr; ls_we = tv[i].lswe; ls_addr = tv[i].lsa; ls_wdata = tv[i].lsw;
         step();
      end

      // Reset while the read is waiting for data: the response is dropped.
      do_reset();
      if_req = 1'b1; if_addr = 32'h8;
      step();
      chk("rstmid_gnt", flags(), 32'b100010);
      if_req = 1'b0;
      step();
      rst = 1'b1;
      step();
      chk("rstmid_c3_flags", flags(), 32'h0);
      chk("rstmid_c3_rdata", if_rdata, 32'h0);
      step();
      rst = 1'b0;
      chk("rstmid_c4_flags", flags(), 32'h0);
      step();
      chk("rstmid_c5_flags", flags(), 32'h0);
      if_req = 1'b1; if_addr = 32'h8;
      step();
      chk("rstmid_regnt", flags(), 32'b100010);
      if_req = 1'b0;
      step();
      step();
      chk("rstmid_rvalid", flags(), 32'b010000);
      chk("rstmid_rdata", if_rdata, 32'h00108213);

      // Both requesters hold requests continuously.
      do_reset();
      if_req = 1'b1; if_addr = 32'h0; ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h4;
      ng = 0;
      for (int c = 0; c < 40 && ng < 5; c++) begin
         step();
         if (if_gnt || ls_gnt) begin
            wins[ng] = ls_gnt;
            ng++;
         end
      end
      chk("cont_ngrants", 32'(ng), 32'd5);
      for (int g = 0; g < 5; g++)
         chk($sformatf("cont_win%0d_is_ls", g), 32'(wins[g]), RR ? 32'(g % 2 == 0) : 32'd1);

      // Back-to-back fetches from 0x0 and 0x4.
      do_reset();
      if_req = 1'b1; if_addr = 32'h0;
      step();
      chk("b2b_gnt1", flags(), 32'b100010);
      if_addr = 32'h4;
      step();
      step();
      chk("b2b_rv1", flags(), 32'b010000);
      chk("b2b_rd1", if_rdata, init_val(0));
      step();
      chk("b2b_gnt2", flags(), 32'b100010);
      chk("b2b_addr2", mem_addr, 32'h1);
      if_req = 1'b0;
      step();
      chk("b2b_wait2", flags(), 32'h0);
      step();
      chk("b2b_rv2", flags(), 32'b010000);
      chk("b2b_rd2", if_rdata, 32'hDEADBEEF);

      // MEM_LAT=3 instance.
      do_reset();
      if_req3 = 1'b1; if_addr3 = 32'h14;
      for (int c = 1; c <= 6; c++) begin
         step();
         if (c == 1) if_req3 = 1'b0;
         chk($sformatf("lat3_c%0d_flags", c), flags3(),
             (c == 1) ? 32'b100010 : (c == 5) ? 32'b010000 : 32'h0);
         if (c >= 2 && c <= 4) chk($sformatf("lat3_c%0d_addr", c), mem_addr3, 32'h5);
      end
      chk("lat3_rdata", if_rdata3, 32'hCAFEF00D);
      chk("lat3_ls_rdata", ls_rdata3, 32'h0);

      // Random traffic against a transaction-level model.
      do_reset();
      for (int i = 0; i < 256; i++) mref[i] = wv[i] ? mem[i] : init_val(i);
      free_at = 0; rv_cyc = -1; rv_ls = 0; rv_dat = '0; last_ls = 1'b0;
      p_if = 0; p_ls = 0; if_a = '0; l_a = '0; l_w = '0; l_we = 0;
      e_gif = 0; e_gls = 0; e_rd = 0; e_wr = 0; e_ma = '0; e_wd = '0;
      for (int k = 0; k < 3000; k++) begin
         chk("rnd_gnt", 32'({if_gnt, ls_gnt}), 32'({e_gif, e_gls}));
         chk("rnd_strobe", 32'({mem_rd, mem_wr}), 32'({e_rd, e_wr}));
         if (e_rd || e_wr) chk("rnd_mem_addr", mem_addr, e_ma);
         if (e_wr) chk("rnd_mem_wdata", mem_wdata, e_wd);
         chk("rnd_rvalid", 32'({if_rvalid, ls_rvalid}),
             (rv_cyc == k) ? (rv_ls ? 32'b01 : 32'b10) : 32'b00);
         if (rv_cyc == k) chk("rnd_rdata", rv_ls ? ls_rdata : if_rdata, rv_dat);

         if (e_gif) p_if = 0;
         if (e_gls) p_ls = 0;
         if (!p_if && $urandom_range(0, 2) == 0) begin
            p_if = 1;
            if_a = (32'($urandom_range(16, 63)) << 2) | 32'($urandom_range(0, 3));
         end
         if (!p_ls && $urandom_range(0, 1) == 0) begin
            p_ls = 1;
            l_we = 1'($urandom_range(0, 1));
            l_a  = (32'($urandom_range(16, 63)) << 2) | 32'($urandom_range(0, 3));
            l_w  = $urandom;
         end
         if_req = p_if; if_addr = if_a;
         ls_req = p_ls; ls_we = l_we; ls_addr = l_a; ls_wdata = l_w;

         e_gif = 0; e_gls = 0; e_rd = 0; e_wr = 0;
         if (k >= free_at && (p_if || p_ls)) begin
            win_ls  = (p_if && p_ls) ? (RR ? !last_ls : 1'b1) : p_ls;
            last_ls = win_ls;
            we      = win_ls && l_we;
            a       = win_ls ? l_a : if_a;
            e_gif = !win_ls; e_gls = win_ls; e_rd = !we; e_wr = we;
            e_ma  = a >> 2; e_wd = l_w;
            if (we) begin
               mref[a[9:2]] = l_w;
               free_at = k + 2;
            end else begin
               rv_cyc  = k + 2 + LAT;
               rv_ls   = win_ls;
               rv_dat  = mref[a[9:2]];
               free_at = k + 2 + LAT;
            end
         end
         step();
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

   initial begin
      #1000000;
      n_err++;
      $display("FAIL watchdog: simulation time limit reached before completion");
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $fatal(1, "watchdog");
   end

endmodule
